// File: rtl/sa_locate_if.sv
// rtl/sa_locate_if.sv - request and position stream bundle for sa_locate
interface sa_locate_if #(
  parameter int IDX_W   = 11,
  parameter int ENTRY_W = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [IDX_W-1:0]   req_top;
  logic [IDX_W-1:0]   req_bot;
  logic               pos_valid;
  logic               pos_ready;
  logic [ENTRY_W-1:0] pos_data;
  logic               pos_last;
  logic               done;
  logic [IDX_W-1:0]   count;

  // Requester / position consumer side
  modport master (
    output req_valid, req_top, req_bot, pos_ready,
    input  req_ready, pos_valid, pos_data, pos_last, done, count
  );

  // Locate engine side
  modport slave (
    input  req_valid, req_top, req_bot, pos_ready,
    output req_ready, pos_valid, pos_data, pos_last, done, count
  );
endinterface

// File: rtl/sa_locate.sv
// rtl/sa_locate.sv - streams suffix-array entries of an interval out of a two-port SA SRAM
module sa_locate #(
  parameter int DEPTH      = 18,
  parameter int ENTRIES    = 60,
  parameter int ENTRY_W    = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int IDX_W      = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sa_locate_if.slave                    bus,
  output logic                          rEn,
  output logic [ADDR_WIDTH-1:0]         rAddr0,
  output logic [ADDR_WIDTH-1:0]         rAddr1,
  input  logic [ENTRIES*ENTRY_W-1:0]    rData0,
  input  logic [ENTRIES*ENTRY_W-1:0]    rData1
);
  localparam int                    ROW_W     = ENTRIES * ENTRY_W;
  localparam logic [IDX_W:0]        SA_SIZE   = (IDX_W+1)'(DEPTH * ENTRIES);
  localparam logic [IDX_W-1:0]      ENTRIES_I = IDX_W'(ENTRIES);
  localparam logic [IDX_W-1:0]      TWO_ROWS  = IDX_W'(2 * ENTRIES);
  localparam logic [IDX_W-1:0]      LAST_COL  = IDX_W'(ENTRIES - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_A   = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_FETCH, S_WAIT, S_EMIT, S_DONE
  } state_t;

  state_t state, stateNext;

  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      bot;
  logic [IDX_W-1:0]      col;
  logic [IDX_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] addr0Q;
  logic [ADDR_WIDTH-1:0] addr1Q;
  logic                  sel;
  logic [ROW_W-1:0]      buf0;
  logic [ROW_W-1:0]      buf1;

  logic                  accept;
  logic                  handshake;
  logic                  lastPos;
  logic                  colWrap;
  logic [ADDR_WIDTH:0]   rowPlus1;
  logic [ADDR_WIDTH-1:0] pairAddr;
  logic [ENTRY_W-1:0]    entry;

  assign accept    = bus.req_valid && (state == S_IDLE);
  assign handshake = (state == S_EMIT) && bus.pos_ready;
  assign lastPos   = (({1'b0, idx} + 1'b1) == {1'b0, bot});
  assign colWrap   = (col == LAST_COL);
  assign rowPlus1  = {1'b0, row} + 1'b1;
  // The partner row saturates at the last SRAM row; its data is never used then.
  assign pairAddr  = (rowPlus1 >= DEPTH_A) ? row : rowPlus1[ADDR_WIDTH-1:0];
  assign entry     = sel ? buf1[col*ENTRY_W +: ENTRY_W] : buf0[col*ENTRY_W +: ENTRY_W];

  // SRAM port drive: addresses are live during FETCH and held afterwards
  assign rEn    = (state == S_FETCH);
  assign rAddr0 = (state == S_FETCH) ? row      : addr0Q;
  assign rAddr1 = (state == S_FETCH) ? pairAddr : addr1Q;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.pos_valid = (state == S_EMIT);
  assign bus.pos_data  = (state == S_EMIT) ? entry : '0;
  assign bus.pos_last  = (state == S_EMIT) && lastPos;
  assign bus.done      = (state == S_DONE);
  assign bus.count     = cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= stateNext;
  end

  // Next-state decode
  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE:  if (accept) stateNext = S_DIV;
      S_DIV: begin
        // An empty interval (also any top beyond the array) skips the SRAM entirely.
        if (idx >= bot)          stateNext = S_DONE;
        else if (col < TWO_ROWS) stateNext = S_FETCH;
      end
      S_FETCH: stateNext = S_WAIT;
      S_WAIT:  stateNext = S_EMIT;
      S_EMIT: begin
        if (handshake) begin
          if (lastPos)             stateNext = S_DONE;
          else if (colWrap && sel) stateNext = S_FETCH;
        end
      end
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Datapath: index split, row-pair buffering and emit bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      bot    <= '0;
      col    <= '0;
      row    <= '0;
      cnt    <= '0;
      sel    <= 1'b0;
      addr0Q <= '0;
      addr1Q <= '0;
      buf0   <= '0;
      buf1   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            idx <= bus.req_top;
            bot <= ({1'b0, bus.req_bot} > SA_SIZE) ? SA_SIZE[IDX_W-1:0] : bus.req_bot;
            col <= bus.req_top;
            row <= '0;
            cnt <= '0;
            sel <= 1'b0;
          end
        end
        S_DIV: begin
          if ((idx < bot) && (col >= ENTRIES_I)) begin
            col <= col - ENTRIES_I;
            row <= row + 1'b1;
          end
        end
        S_FETCH: begin
          addr0Q <= rAddr0;
          addr1Q <= rAddr1;
        end
        S_WAIT: begin
          buf0 <= rData0;
          buf1 <= rData1;
          sel  <= 1'b0;
        end
        S_EMIT: begin
          if (handshake) begin
            idx <= idx + 1'b1;
            cnt <= cnt + 1'b1;
            if (colWrap) begin
              col <= '0;
              row <= row + 1'b1;
              sel <= ~sel;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_locate.sv
// tb/tb_sa_locate.sv - randomized self-checking bench for sa_locate
module tb_sa_locate;
  localparam int DEPTH   = 18;
  localparam int ENTRIES = 60;
  localparam int ENTRY_W = 32;
  localparam int AW      = 5;
  localparam int IDX_W   = 11;
  localparam int SA_N    = DEPTH * ENTRIES;
  localparam int ROW_W   = ENTRIES * ENTRY_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rEn;
  logic [AW-1:0]    rAddr0, rAddr1;
  logic [ROW_W-1:0] rData0 = '0, rData1 = '0;
  logic [31:0]      sa [SA_N];

  int checks = 0;
  int failures = 0;

  sa_locate_if #(.IDX_W(IDX_W), .ENTRY_W(ENTRY_W)) bus ();

  sa_locate #(
    .DEPTH(DEPTH), .ENTRIES(ENTRIES), .ENTRY_W(ENTRY_W), .ADDR_WIDTH(AW), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rEn(rEn), .rAddr0(rAddr0), .rAddr1(rAddr1), .rData0(rData0), .rData1(rData1)
  );

  always #5 clk = ~clk;

  function automatic logic [ROW_W-1:0] packRow(input logic [AW-1:0] a);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int k = 0; k < ENTRIES; k++)
      if (int'(a) < DEPTH) r[k*ENTRY_W +: ENTRY_W] = sa[int'(a)*ENTRIES + k];
    return r;
  endfunction

  // Synchronous-read SRAM: data appears the cycle after rEn
  always @(posedge clk) begin
    if (rEn) begin
      rData0 <= packRow(rAddr0);
      rData1 <= packRow(rAddr1);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode: 0 always ready, 1 ready one cycle in three, 2 random ready
  // abortAfter: apply reset once this many positions have been accepted (0 = never)
  task automatic runInterval(input int top, input int bot, input int mode, input int abortAfter);
    logic [31:0] q[$];
    logic [31:0] prevData;
    logic        prevLast;
    bit          prevStall, finished, aborted;
    int          hi, n, cyc, got, fetches, expFetches, firstHs, lastHs, rowTop;
    hi = (bot > SA_N) ? SA_N : bot;
    for (int i = top; i < hi; i++) q.push_back(sa[i]);
    n = q.size();
    rowTop = top / ENTRIES;
    expFetches = (n == 0) ? 0 : (((hi - 1) / ENTRIES - rowTop) / 2 + 1);

    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_top   = IDX_W'(top);
    bus.req_bot   = IDX_W'(bot);
    @(negedge clk);
    bus.req_valid = 1'b0;

    cyc = 0; got = 0; fetches = 0; firstHs = -1; lastHs = -1;
    prevStall = 0; prevData = '0; prevLast = 0; finished = 0; aborted = 0;
    while (!finished && cyc < 3000) begin
      case (mode)
        0:       bus.pos_ready = 1'b1;
        1:       bus.pos_ready = (cyc % 3 == 0);
        default: bus.pos_ready = 1'($urandom_range(0, 1));
      endcase
      if (rEn) begin
        fetches++;
        if (fetches == 1) begin
          check("first_rAddr0", rAddr0, rowTop);
          check("first_rAddr1", rAddr1, (rowTop + 1 >= DEPTH) ? rowTop : rowTop + 1);
        end
      end
      if (prevStall) begin
        check("stall_valid", bus.pos_valid, 1);
        check("stall_data", bus.pos_data, prevData);
        check("stall_last", bus.pos_last, prevLast);
      end
      prevStall = 0;
      if (bus.pos_valid) begin
        if (bus.pos_ready) begin
          check("extra_pos", q.size() > 0, 1);
          if (q.size() > 0) begin
            check("pos_data", bus.pos_data, q[0]);
            check("pos_last", bus.pos_last, q.size() == 1);
            void'(q.pop_front());
          end
          got++;
          if (firstHs < 0) firstHs = cyc;
          lastHs = cyc;
          if (abortAfter > 0 && got == abortAfter) begin
            rst_n = 1'b0;
            @(negedge clk);
            check("abort_pos_valid", bus.pos_valid, 0);
            check("abort_req_ready", bus.req_ready, 1);
            check("abort_done", bus.done, 0);
            check("abort_rEn", rEn, 0);
            rst_n = 1'b1;
            aborted = 1;
            finished = 1;
          end
        end else begin
          prevStall = 1;
          prevData  = bus.pos_data;
          prevLast  = bus.pos_last;
        end
      end
      if (!aborted) begin
        if (bus.done) begin
          check("count", bus.count, n);
          check("positions", got, n);
          check("fetches", fetches, expFetches);
          if (mode == 0 && n > 0) check("throughput", lastHs - firstHs + 1, n + 2 * (expFetches - 1));
          finished = 1;
        end else begin
          check("req_ready_busy", bus.req_ready, 0);
        end
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("interval_finished", finished, 1);
    @(negedge clk);
    if (!aborted) begin
      check("done_pulse", bus.done, 0);
      check("count_hold", bus.count, n);
    end
    bus.pos_ready = 1'b0;
  endtask

  initial begin
    int t, b;
    bus.req_valid = 1'b0;
    bus.req_top   = '0;
    bus.req_bot   = '0;
    bus.pos_ready = 1'b0;
    for (int i = 0; i < SA_N; i++) sa[i] = $urandom;
    for (int k = 0; k < ENTRIES; k++) sa[k] = 32'(1000 + k);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rEn", rEn, 0);
    check("rst_rAddr0", rAddr0, 0);
    check("rst_rAddr1", rAddr1, 0);
    check("rst_pos_valid", bus.pos_valid, 0);
    check("rst_pos_data", bus.pos_data, 0);
    check("rst_pos_last", bus.pos_last, 0);
    check("rst_done", bus.done, 0);
    check("rst_count", bus.count, 0);
    rst_n = 1'b1;

    runInterval(5, 8, 0, 0);
    for (int k = 0; k < ENTRIES; k++) begin
      sa[k] = 32'(k);
      sa[ENTRIES + k] = 32'(100 + k);
    end
    runInterval(58, 63, 0, 0);
    runInterval(118, 122, 0, 0);
    runInterval(10, 10, 0, 0);
    runInterval(1079, 2000, 0, 0);
    runInterval(0, 4, 1, 0);
    runInterval(0, 50, 0, 20);
    runInterval(2, 3, 0, 0);
    runInterval(100, 300, 0, 0);
    runInterval(1500, 1600, 0, 0);
    for (int r = 0; r < 8; r++) begin
      t = $urandom_range(0, SA_N + 20);
      b = t + $urandom_range(0, 150);
      if (b > 2047) b = 2047;
      runInterval(t, b, (r % 2 == 0) ? 2 : 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
